fetch_queue: RTL and testbench

Instruction fetch stage that sits directly upstream of the single-cycle datapath's decode/execute logic. It owns the fetch PC, issues one-outstanding instruction-memory requests over a request/response handshake, and buffers returned 32-bit instructions with their PCs in a DEPTH-entry FIFO. Each instruction is presented to the consumer over a valid/ready interface. A redirect from the NextPC/branch logic flushes the queue and restarts fetch at the target, discarding any in-flight response.

---
 rtl/fetch_queue.sv | 154 +++++++++++++++
 tb/tb_fetch_queue.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_queue
//  Purpose  : Instruction fetch stage. Owns the fetch PC, issues one
//             outstanding instruction-memory request at a time and buffers
//             returned {instr, pc} pairs in a DEPTH-entry FIFO that feeds the
//             decode stage over valid/ready. A redirect flushes the queue and
//             restarts fetch, discarding any response still in flight.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     reset_n,
    input  logic [63:0]              startpc,
    output logic                     imem_req,
    output logic [63:0]              imem_addr,
    input  logic                     imem_valid,
    input  logic [31:0]              imem_data,
    input  logic                     redirect,
    input  logic [63:0]              redirect_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_instr,
    output logic [63:0]              out_pc,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int                c_PTR_W = $clog2(DEPTH);
    localparam logic [c_PTR_W:0]  c_FULL  = (c_PTR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_BOOT    = 2'd0,
        S_REQ     = 2'd1,
        S_HOLD    = 2'd2,
        S_DISCARD = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [63:0]          fetch_pc_q, fetch_pc_d;
    logic [c_PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [c_PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [c_PTR_W:0]     count_q, count_d;

    logic [31:0]          instr_mem_q [DEPTH];
    logic [63:0]          pc_mem_q    [DEPTH];

    logic                 do_push;
    logic                 do_pop;

    // Word-alignment drops the two low address bits of both PC sources.
    logic                 unused_lsbs;
    assign unused_lsbs = ^{startpc[1:0], redirect_pc[1:0]};

    assign out_valid = (count_q != '0);
    assign do_pop    = out_valid & out_ready;
    assign imem_req  = (state_q == S_REQ);
    assign imem_addr = fetch_pc_q;
    assign count     = count_q;
    // Gate the head with out_valid so the unreset storage never leaks out.
    assign out_instr = out_valid ? instr_mem_q[rd_ptr_q] : 32'd0;
    assign out_pc    = out_valid ? pc_mem_q[rd_ptr_q]    : 64'd0;

    // Next-state: redirect outranks everything except BOOT, which ignores it.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        do_push    = 1'b0;

        if (redirect && (state_q != S_BOOT)) begin
            // Flush: any same-cycle pop is simply absorbed by the reset.
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            fetch_pc_d = {redirect_pc[63:2], 2'b00};
            unique case (state_q)
                S_REQ:     state_d = imem_valid ? S_REQ : S_DISCARD;
                S_HOLD:    state_d = S_REQ;
                S_DISCARD: state_d = imem_valid ? S_REQ : S_DISCARD;
                default:   state_d = state_q;
            endcase
        end else begin
            do_push = (state_q == S_REQ) && imem_valid;
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase

            unique case (state_q)
                S_BOOT: begin
                    fetch_pc_d = {startpc[63:2], 2'b00};
                    state_d    = S_REQ;
                end
                S_REQ: begin
                    if (imem_valid) begin
                        fetch_pc_d = fetch_pc_q + 64'd4;
                        if (count_d == c_FULL) begin
                            state_d = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (count_d != c_FULL) begin
                        state_d = S_REQ;
                    end
                end
                S_DISCARD: begin
                    if (imem_valid) begin
                        state_d = S_REQ;
                    end
                end
                default: state_d = S_BOOT;
            endcase
        end
    end

    // Control state and pointers, cleared asynchronously.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_BOOT;
            fetch_pc_q <= 64'd0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // FIFO storage; contents are only observable behind out_valid.
    always_ff @(posedge CLK) begin
        if (do_push) begin
            instr_mem_q[wr_ptr_q] <= imem_data;
            pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_fetch_queue
//  Purpose  : Randomised bench for fetch_queue with a memory responder, a
//             stream-level reference model and a scoreboard monitor.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_queue;

    localparam int DEPTH = 4;

    logic        CLK = 1'b0;
    logic        reset_n;
    logic [63:0] startpc;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_data;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic [$clog2(DEPTH):0] count;

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .CLK         (CLK),
        .reset_n     (reset_n),
        .startpc     (startpc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_valid  (imem_valid),
        .imem_data   (imem_data),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .count       (count)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] ins;
    } ent_t;

    ent_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   pops    = 0;

    // Instruction word stored at a given address in the bench's memory.
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return (a[33:2] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1357_2468;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: occupancy must track the model, and every pop must match the head.
    ent_t mon_e;
    always @(negedge CLK) begin
        chk("count", 64'(count), 64'(exp_q.size()));
        chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
        if (count == DEPTH) chk("req_when_full", 64'(imem_req), 64'd0);
        if (out_valid && out_ready && exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("out_pc", out_pc, mon_e.pc);
            chk("out_instr", 64'(out_instr), 64'(mon_e.ins));
            pops++;
        end
    end

    // Memory responder state and reference-model state.
    logic        busy;
    int          lat;
    logic [63:0] m_addr;
    int          m_ep;
    logic [63:0] rsp_addr;
    int          rsp_ep;
    int          epoch;
    logic        booted;
    logic [63:0] m_pc;
    int          first_req;
    int          first_ov;
    logic        wrap_mode;
    int          wrap_caps;
    int          wrap_cyc1;
    ent_t        tmp;

    task automatic chk_reset_outputs();
        chk("rst_imem_req", 64'(imem_req), 64'd0);
        chk("rst_imem_addr", imem_addr, 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_instr", 64'(out_instr), 64'd0);
        chk("rst_out_pc", out_pc, 64'd0);
        chk("rst_count", 64'(count), 64'd0);
    endtask

    initial begin
        reset_n     = 1'b0;
        startpc     = 64'h1000;
        imem_valid  = 1'b0;
        imem_data   = 32'd0;
        redirect    = 1'b0;
        redirect_pc = 64'd0;
        out_ready   = 1'b0;
        busy = 1'b0; lat = 0; m_addr = '0; m_ep = 0; rsp_addr = '0; rsp_ep = -1;
        epoch = 0; booted = 1'b0; m_pc = '0;
        first_req = -1; first_ov = -1;
        wrap_mode = 1'b0; wrap_caps = 0; wrap_cyc1 = 0;

        repeat (2) @(posedge CLK);
        #1;
        chk_reset_outputs();
        reset_n   = 1'b1;
        out_ready = 1'b1;

        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(posedge CLK);
            // Reference model: what this edge does to the instruction stream.
            if (reset_n) begin
                if (!booted) begin
                    m_pc   = {startpc[63:2], 2'b00};
                    booted = 1'b1;
                end else if (redirect) begin
                    exp_q.delete();
                    m_pc = {redirect_pc[63:2], 2'b00};
                    epoch++;
                end else if (imem_valid && rsp_ep == epoch) begin
                    tmp.pc  = rsp_addr;
                    tmp.ins = imem_data;
                    exp_q.push_back(tmp);
                    m_pc = m_pc + 64'd4;
                end
            end
            #1;

            imem_valid = 1'b0;
            redirect   = 1'b0;

            if (cyc == 700 || cyc == 900) begin
                reset_n = 1'b0;
                busy    = 1'b0;
                booted  = 1'b0;
                exp_q.delete();
                #1;
                chk_reset_outputs();
                startpc = (cyc == 700) ? {$urandom, $urandom} : 64'hFFFF_FFFF_FFFF_FFFC;
            end else if (cyc == 703 || cyc == 903) begin
                reset_n   = 1'b1;
                wrap_mode = (cyc == 903);
                wrap_caps = 0;
            end

            if (!reset_n) begin
                out_ready = 1'b0;
            end else begin
                if (out_valid && first_ov < 0) first_ov = cyc;
                if (cyc == 30) chk("first_valid_latency", 64'(first_ov - first_req), 64'd2);
                if (cyc == 59) begin
                    chk("bp_count_full", 64'(count), 64'(DEPTH));
                    chk("bp_req_low", 64'(imem_req), 64'd0);
                end
                if (cyc == 60) chk("bp_req_resume", 64'(imem_req), 64'd1);

                if (cyc < 40 || (cyc >= 903 && cyc <= 920) || (cyc >= 703 && cyc < 710))
                    out_ready = 1'b1;
                else if ((cyc >= 40 && cyc < 59) || (cyc >= 690 && cyc < 700))
                    out_ready = 1'b0;
                else if (cyc == 59)
                    out_ready = 1'b1;
                else
                    out_ready = ($urandom_range(0, 9) < 7);

                if (cyc == 703) begin
                    // Ignored in BOOT: fetch must still start at startpc.
                    redirect    = 1'b1;
                    redirect_pc = {$urandom, $urandom};
                end else if (cyc > 60 && !(cyc >= 690 && cyc <= 710) && !(cyc >= 890 && cyc <= 920)
                             && $urandom_range(0, 99) < 5) begin
                    redirect    = 1'b1;
                    redirect_pc = {$urandom, $urandom};
                end

                // Memory: one outstanding request, latency 0..3 cycles.
                if (busy) begin
                    if (imem_req) chk("addr_stable", imem_addr, m_addr);
                    if (lat > 0) lat--;
                end else if (imem_req) begin
                    chk("fetch_addr", imem_addr, m_pc);
                    chk("addr_align", 64'(imem_addr[1:0]), 64'd0);
                    m_addr = imem_addr;
                    m_ep   = epoch;
                    busy   = 1'b1;
                    if (cyc < 40)      lat = 1;
                    else if (wrap_mode) lat = 0;
                    else               lat = $urandom_range(0, 3);
                    if (first_req < 0) first_req = cyc;
                    if (wrap_mode) begin
                        wrap_caps++;
                        if (wrap_caps == 1) wrap_cyc1 = cyc;
                        if (wrap_caps == 2) begin
                            chk("wrap_addr", imem_addr, 64'd0);
                            chk("wrap_no_stall", 64'(cyc - wrap_cyc1), 64'd1);
                        end
                    end
                end
                if (busy && lat == 0) begin
                    imem_valid = 1'b1;
                    imem_data  = mem_word(m_addr);
                    rsp_addr   = m_addr;
                    rsp_ep     = m_ep;
                    busy       = 1'b0;
                end
            end
        end

        chk("min_pops", 64'(pops >= 200), 64'd1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
